// File: rtl/regfile_port_arbiter.sv
// Two-requester round-robin arbiter sharing the register file's read and write port.
// Supports locked sequences so one requester can run an uninterrupted read-modify-write.
module regfile_port_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_write,
    input  logic                   req0_lock,
    input  logic [INDEX_WIDTH-1:0] req0_index,
    input  logic [DATA_WIDTH-1:0]  req0_wdata,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_write,
    input  logic                   req1_lock,
    input  logic [INDEX_WIDTH-1:0] req1_index,
    input  logic [DATA_WIDTH-1:0]  req1_wdata,
    output logic                   rsp0_valid,
    output logic [DATA_WIDTH-1:0]  rsp0_rdata,
    output logic                   rsp1_valid,
    output logic [DATA_WIDTH-1:0]  rsp1_rdata,
    output logic [INDEX_WIDTH-1:0] rf_read_index,
    input  logic [DATA_WIDTH-1:0]  rf_read_data,
    output logic [INDEX_WIDTH-1:0] rf_write_index,
    output logic                   rf_write_enable,
    output logic [DATA_WIDTH-1:0]  rf_write_data
);
    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_e;

    lock_state_e            state_q, state_d;
    logic                   prio_q, prio_d;   // 1: requester 1 wins a tie
    logic                   gnt0, gnt1, acc, acc_write, acc_lock;
    logic [INDEX_WIDTH-1:0] acc_index;
    logic [DATA_WIDTH-1:0]  acc_wdata;
    logic                   rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0]  rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        prio_d  = prio_q;
        if (!reset) begin
            case (state_q)
                UNLOCKED: begin
                    if (req0_valid && (!req1_valid || !prio_q)) gnt0 = 1'b1;
                    else if (req1_valid)                        gnt1 = 1'b1;
                end
                LOCKED0: gnt0 = req0_valid;
                LOCKED1: gnt1 = req1_valid;
                default: ;
            endcase
        end
        acc       = gnt0 | gnt1;
        acc_write = gnt0 ? req0_write : req1_write;
        acc_lock  = gnt0 ? req0_lock  : req1_lock;
        acc_index = gnt0 ? req0_index : req1_index;
        acc_wdata = gnt0 ? req0_wdata : req1_wdata;
        // Entering a lock already hands priority to the other side, so the
        // pointer update below is a no-op for accepts inside a locked sequence.
        if (acc) begin
            state_d = acc_lock ? (gnt0 ? LOCKED0 : LOCKED1) : UNLOCKED;
            prio_d  = gnt0;
        end
    end

    assign req0_ready      = gnt0;
    assign req1_ready      = gnt1;
    assign rf_write_enable = acc & acc_write;
    assign rf_write_index  = rf_write_enable ? acc_index : '0;
    assign rf_write_data   = rf_write_enable ? acc_wdata : '0;
    assign rf_read_index   = (acc && !acc_write) ? acc_index : '0;

    assign rsp0_valid_d = gnt0 & ~req0_write;
    assign rsp1_valid_d = gnt1 & ~req1_write;
    assign rsp0_rdata_d = rsp0_valid_d ? rf_read_data : rsp0_rdata_q;
    assign rsp1_rdata_d = rsp1_valid_d ? rf_read_data : rsp1_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= UNLOCKED;
            prio_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    // Masking with reset drops a response whose read was accepted just before reset.
    assign rsp0_valid = rsp0_valid_q & ~reset;
    assign rsp1_valid = rsp1_valid_q & ~reset;
    assign rsp0_rdata = reset ? '0 : rsp0_rdata_q;
    assign rsp1_rdata = reset ? '0 : rsp1_rdata_q;
endmodule
